use_record_framer: RTL and testbench
====================================

# use_record_framer

Single-instance successor to the token-ring stream element array. It parses an unbroken byte stream of delimited records, each made of a variable field, one delimiter byte and a fixed-length field, arriving W bytes per beat. Completed records go into an internal record FIFO and are presented on a valid/ready output. Bus width, field lengths, delimiter and FIFO depth are parameters. It adds input backpressure and overlong-field recovery, and it sits between the DMA-side AXI-Stream input and the compressor core.

## Interface
- DATA_BUS_WIDTH_BYTES, 8, bytes per input beat; byte 0 at [7:0] is processed first.
- FIXEDFIELD_LENGTH_BYTES, 17, fixed-field length in bytes after the delimiter; must be ≥ DATA_BUS_WIDTH_BYTES−1.
- MAX_VARIABLEFIELD_LENGTH, 16, maximum variable-field bytes before the delimiter.
- VARIABLEFIELD_DELIMITER, 8'h2C, delimiter byte value.
- RECORD_FIFO_DEPTH, 4, number of record slots; power of 2, ≥ 2.
- Derived values (localparams):
  - MAX_RECORD_BYTES = MAX_VARIABLEFIELD_LENGTH+1+FIXEDFIELD_LENGTH_BYTES.
  - LEN_W = $clog2(MAX_RECORD_BYTES+1).
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-low.
- dataIn  in  DATA_BUS_WIDTH_BYTES*8  input beat.
- dataInValid  in  1  beat valid.
- dataInReady  out  1  beat accepted when valid&&ready.
- recordOut  out  MAX_RECORD_BYTES*8  head record; byte 0 at [7:0]; unused bytes zero.
- recordByteLength  out  LEN_W  head record length in bytes.
- recordValid  out  1  FIFO not empty.
- recordReady  in  1  pop when valid&&ready.
- fifoLevel  out  $clog2(RECORD_FIFO_DEPTH+1)  occupied slots.
- frameErrorPulse  out  1  one-cycle pulse when an overlong record has been fully discarded.
- errCount  out  16  saturating discarded-record count; present only under USE_FRAMER_ERRCNT_EN.

## Operation
- Per-byte FSM, advanced sequentially across the bytes of each accepted beat within one cycle. States:
  - VAR: append the byte to the record buffer. On the delimiter, append it and go to FIX. On a non-delimiter byte when the variable count already equals MAX_VARIABLEFIELD_LENGTH, go to DROP_VAR.
  - FIX: append the byte; any value, including the delimiter, is data. On the FIXEDFIELD_LENGTH_BYTES-th byte, push {buffer, length} to the FIFO, clear the buffer and go to VAR.
  - DROP_VAR: discard bytes until the delimiter, then go to DROP_FIX.
  - DROP_FIX: discard FIXEDFIELD_LENGTH_BYTES bytes, pulse frameErrorPulse, then go to VAR.
- A zero-length variable field (delimiter as the first byte) is legal and gives length FIXEDFIELD_LENGTH_BYTES+1.
- The parameter constraint guarantees at most one record completes per beat, so there is at most one FIFO push per cycle.
- dataInReady = (fifoLevel < RECORD_FIFO_DEPTH); it is registered-state derived, with no combinational path from dataInValid.
- Records are never dropped for lack of space. A partial record is held across idle cycles indefinitely.
- Push and pop in the same cycle leave fifoLevel unchanged. Pop from empty is ignored.

## Timing
- Reset values:
  - dataInReady=1, recordValid=0, recordOut=0, recordByteLength=0.
  - fifoLevel=0, frameErrorPulse=0, errCount=0, FSM=VAR, buffer cleared.
- A beat completing a record, accepted at edge N, gives recordValid=1 after edge N (one-cycle latency); the head is stable until popped.
- The FIFO is first-word-fall-through. After a pop at edge N, the next record is visible after edge N.
- dataInReady deasserts after the edge that fills the last slot and reasserts after the edge of the next pop.
- frameErrorPulse is high for exactly the one cycle after the beat containing the last discarded byte.
- Reset asserted mid-record: the partial record and all FIFO contents are lost immediately (asynchronous). Parsing restarts in VAR with the first beat after deassertion.

## Configuration
- USE_FRAMER_ERRCNT_EN defined:
  - errCount port present.
  - It increments on each frameErrorPulse, saturates at 16'hFFFF and is cleared only by reset.
- Macro undefined: no errCount port and no counter logic; all other behaviour is identical.

## Structure
- Package use_framer_pkg holds:
  - the default parameter constants;
  - the FSM state enum (VAR, FIX, DROP_VAR, DROP_FIX);
  - the record struct typedef {bytes, length}.
- One sub-module, use_record_fifo: parametrised depth/width, FWFT, level output.
- The framer FSM and byte-assembly logic stay in the top module.

## Test plan
- 20 records of lengths 27,21,21,24,31,19,26,23,33,33,31,19,19,20,29,19,30,19,20,21, streamed back-to-back at W=8, fixed-field last byte 0x2C, recordReady=1 → 20 records in order, byte0 = index 0..19, lengths match.
- recordReady=0 and 5 records of length 21 sent → fifoLevel=4 and dataInReady=0 after the 4th push. Raise recordReady → all 5 delivered in order, none lost.
- 20 non-delimiter bytes, then 0x2C plus 17 bytes, then a valid record of length 21 → frameErrorPulse exactly once, no record from the bad data, next record length 21; errCount=1 with the macro.
- 0x2C as the first byte plus 17 fixed bytes → one record, length 18, byte0=8'h2C.
- Reset pulled low mid-way through the 3rd of 5 records, then released and 2 fresh records sent → outputs at reset values during reset; exactly 2 records delivered afterwards.
- The first scenario with dataInValid toggled 1-0-1-0 → output sequence identical to the first scenario.

Source files
------------

// File: rtl/use_framer_pkg.sv
// Shared definitions for the delimited-record framer: default parameter values,
// the per-byte parser state and the default-size record payload.
package use_framer_pkg;

  localparam int unsigned DEF_DATA_BUS_WIDTH_BYTES     = 8;
  localparam int unsigned DEF_FIXEDFIELD_LENGTH_BYTES  = 17;
  localparam int unsigned DEF_MAX_VARIABLEFIELD_LENGTH = 16;
  localparam logic [7:0]  DEF_VARIABLEFIELD_DELIMITER  = 8'h2C;
  localparam int unsigned DEF_RECORD_FIFO_DEPTH        = 4;

  localparam int unsigned DEF_MAX_RECORD_BYTES =
    DEF_MAX_VARIABLEFIELD_LENGTH + 1 + DEF_FIXEDFIELD_LENGTH_BYTES;
  localparam int unsigned DEF_LEN_W = $clog2(DEF_MAX_RECORD_BYTES + 1);

  // Per-byte parser state
  typedef enum logic [1:0] {
    VAR      = 2'd0,
    FIX      = 2'd1,
    DROP_VAR = 2'd2,
    DROP_FIX = 2'd3
  } framer_state_t;

  // One assembled record at the default sizes: byte 0 in bytes[7:0], unused bytes zero
  typedef struct packed {
    logic [DEF_MAX_RECORD_BYTES*8-1:0] bytes;
    logic [DEF_LEN_W-1:0]              length;
  } record_t;

endpackage

// File: rtl/use_record_fifo.sv
// First-word-fall-through record FIFO built as a shift register, so the head
// entry is always slot 0 and every output comes straight from a flop.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   pushValid       write pushData this cycle (ignored when full with no pop)
//   pushData        entry to store
//   pop             consume the head entry (ignored when empty)
//   headData        head entry, zero when empty
//   headValid       FIFO not empty
//   level           occupied slots
//   notFull         level < DEPTH
module use_record_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             headValid,
  output logic [LVL_W-1:0] level,
  output logic             notFull
);

  logic [WIDTH-1:0] slots   [DEPTH];
  logic [WIDTH-1:0] shifted [DEPTH];
  logic             doPop;
  logic             doPush;
  logic [LVL_W-1:0] wrIdx;
  logic [LVL_W-1:0] levelNext;

  // Slots at or above the level are kept at zero, so a pop shifts zeros in
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = slots[i+1];
    end
    shifted[DEPTH-1] = '0;
  end

  always_comb begin
    doPop     = pop && (level != '0);
    doPush    = pushValid && ((level != LVL_W'(DEPTH)) || doPop);
    wrIdx     = level - LVL_W'(doPop);
    levelNext = level + LVL_W'(doPush) - LVL_W'(doPop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      level     <= '0;
      headValid <= 1'b0;
      notFull   <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (doPush && (LVL_W'(i) == wrIdx)) begin
          slots[i] <= pushData;
        end else if (doPop) begin
          slots[i] <= shifted[i];
        end
      end
      level     <= levelNext;
      headValid <= (levelNext != '0);
      notFull   <= (levelNext < LVL_W'(DEPTH));
    end
  end

  assign headData = slots[0];

endmodule

// File: rtl/use_record_framer.sv
// Delimited-record framer: parses an unbroken byte stream of records
// (variable field, delimiter, fixed field), W bytes per beat, into a record FIFO.
// Overlong variable fields are discarded through to the end of their fixed field.
// Optional feature macro: USE_FRAMER_ERRCNT_EN adds the errCount port and counter.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   dataIn            input beat, byte 0 at [7:0] parsed first
//   dataInValid       beat valid
//   dataInReady       beat accepted on valid && ready (FIFO has a free slot)
//   recordOut         head record, byte 0 at [7:0], unused bytes zero
//   recordByteLength  head record length in bytes
//   recordValid       FIFO not empty
//   recordReady       pop head on valid && ready
//   fifoLevel         occupied record slots
//   frameErrorPulse   one cycle after an overlong record has been fully discarded
//   errCount          saturating discarded-record count (macro only)
module use_record_framer
  import use_framer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH_BYTES     = DEF_DATA_BUS_WIDTH_BYTES,
  parameter int unsigned FIXEDFIELD_LENGTH_BYTES  = DEF_FIXEDFIELD_LENGTH_BYTES,
  parameter int unsigned MAX_VARIABLEFIELD_LENGTH = DEF_MAX_VARIABLEFIELD_LENGTH,
  parameter logic [7:0]  VARIABLEFIELD_DELIMITER  = DEF_VARIABLEFIELD_DELIMITER,
  parameter int unsigned RECORD_FIFO_DEPTH        = DEF_RECORD_FIFO_DEPTH,
  localparam int unsigned MAX_RECORD_BYTES =
    MAX_VARIABLEFIELD_LENGTH + 1 + FIXEDFIELD_LENGTH_BYTES,
  localparam int unsigned LEN_W = $clog2(MAX_RECORD_BYTES + 1),
  localparam int unsigned LVL_W = $clog2(RECORD_FIFO_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_BUS_WIDTH_BYTES*8-1:0] dataIn,
  input  logic                              dataInValid,
  output logic                              dataInReady,
  output logic [MAX_RECORD_BYTES*8-1:0]     recordOut,
  output logic [LEN_W-1:0]                  recordByteLength,
  output logic                              recordValid,
  input  logic                              recordReady,
  output logic [LVL_W-1:0]                  fifoLevel,
  output logic                              frameErrorPulse
`ifdef USE_FRAMER_ERRCNT_EN
  ,
  output logic [15:0]                       errCount
`endif
);

  localparam int unsigned BUF_W  = MAX_RECORD_BYTES * 8;
  localparam int unsigned REC_W  = BUF_W + LEN_W;
  localparam int unsigned VCNT_W = $clog2(MAX_VARIABLEFIELD_LENGTH + 1);
  localparam int unsigned FCNT_W = $clog2(FIXEDFIELD_LENGTH_BYTES + 1);

  framer_state_t     state,  stNext;
  logic [VCNT_W-1:0] varCnt, varNext;
  logic [FCNT_W-1:0] fixCnt, fixNext;
  logic [BUF_W-1:0]  bufBytes, bufNext;
  logic [LEN_W-1:0]  bufLen, lenNext;
  logic              pushValid;
  logic [BUF_W-1:0]  pushBytes;
  logic [LEN_W-1:0]  pushLen;
  logic              dropDone;
  logic [7:0]        curByte;
  logic              beatAccept;
  logic [REC_W-1:0]  headData;

  // Write one byte at a runtime position without a variable part-select
  function automatic logic [BUF_W-1:0] putByte(input logic [BUF_W-1:0] buffer,
                                               input logic [LEN_W-1:0] pos,
                                               input logic [7:0]       value);
    logic [BUF_W-1:0] res;
    res = buffer;
    for (int k = 0; k < MAX_RECORD_BYTES; k++) begin
      if (LEN_W'(k) == pos) res[k*8 +: 8] = value;
    end
    return res;
  endfunction

  assign beatAccept = dataInValid && dataInReady;

  // Walk the beat byte by byte; the fixed-field length bound keeps it to one push per beat
  always_comb begin
    stNext    = state;
    varNext   = varCnt;
    fixNext   = fixCnt;
    bufNext   = bufBytes;
    lenNext   = bufLen;
    pushValid = 1'b0;
    pushBytes = '0;
    pushLen   = '0;
    dropDone  = 1'b0;
    curByte   = 8'h00;
    if (beatAccept) begin
      for (int i = 0; i < DATA_BUS_WIDTH_BYTES; i++) begin
        curByte = dataIn[i*8 +: 8];
        case (stNext)
          VAR: begin
            if (curByte == VARIABLEFIELD_DELIMITER) begin
              bufNext = putByte(bufNext, lenNext, curByte);
              lenNext = lenNext + LEN_W'(1);
              fixNext = '0;
              stNext  = FIX;
            end else if (varNext == VCNT_W'(MAX_VARIABLEFIELD_LENGTH)) begin
              // Overlong: nothing of this record survives
              bufNext = '0;
              lenNext = '0;
              varNext = '0;
              stNext  = DROP_VAR;
            end else begin
              bufNext = putByte(bufNext, lenNext, curByte);
              lenNext = lenNext + LEN_W'(1);
              varNext = varNext + VCNT_W'(1);
            end
          end
          FIX: begin
            bufNext = putByte(bufNext, lenNext, curByte);
            lenNext = lenNext + LEN_W'(1);
            fixNext = fixNext + FCNT_W'(1);
            if (fixNext == FCNT_W'(FIXEDFIELD_LENGTH_BYTES)) begin
              pushValid = 1'b1;
              pushBytes = bufNext;
              pushLen   = lenNext;
              bufNext   = '0;
              lenNext   = '0;
              varNext   = '0;
              stNext    = VAR;
            end
          end
          DROP_VAR: begin
            if (curByte == VARIABLEFIELD_DELIMITER) begin
              fixNext = '0;
              stNext  = DROP_FIX;
            end
          end
          DROP_FIX: begin
            fixNext = fixNext + FCNT_W'(1);
            if (fixNext == FCNT_W'(FIXEDFIELD_LENGTH_BYTES)) begin
              dropDone = 1'b1;
              varNext  = '0;
              stNext   = VAR;
            end
          end
          default: stNext = VAR;
        endcase
      end
    end
  end

  // Parser state and partial-record buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= VAR;
      varCnt          <= '0;
      fixCnt          <= '0;
      bufBytes        <= '0;
      bufLen          <= '0;
      frameErrorPulse <= 1'b0;
    end else begin
      state           <= stNext;
      varCnt          <= varNext;
      fixCnt          <= fixNext;
      bufBytes        <= bufNext;
      bufLen          <= lenNext;
      frameErrorPulse <= dropDone;
    end
  end

`ifdef USE_FRAMER_ERRCNT_EN
  // Discarded-record counter, sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errCount <= '0;
    end else if (dropDone && (errCount != 16'hFFFF)) begin
      errCount <= errCount + 16'd1;
    end
  end
`endif

  use_record_fifo #(
    .DEPTH (RECORD_FIFO_DEPTH),
    .WIDTH (REC_W)
  ) uRecordFifo (
    .clk       (clk),
    .reset     (reset),
    .pushValid (pushValid),
    .pushData  ({pushBytes, pushLen}),
    .pop       (recordReady),
    .headData  (headData),
    .headValid (recordValid),
    .level     (fifoLevel),
    .notFull   (dataInReady)
  );

  assign recordOut        = headData[REC_W-1:LEN_W];
  assign recordByteLength = headData[LEN_W-1:0];

endmodule

// File: tb/tb_use_record_framer.sv
// Bench for use_record_framer: expected records are built while the byte stream
// is generated, then matched in order against everything the DUT pops.
module tb_use_record_framer;
  import use_framer_pkg::*;

  localparam int unsigned W      = DEF_DATA_BUS_WIDTH_BYTES;
  localparam int unsigned F      = DEF_FIXEDFIELD_LENGTH_BYTES;
  localparam int unsigned V      = DEF_MAX_VARIABLEFIELD_LENGTH;
  localparam logic [7:0]  DELIM  = DEF_VARIABLEFIELD_DELIMITER;
  localparam int unsigned DEPTH  = DEF_RECORD_FIFO_DEPTH;
  localparam int unsigned MAXB   = DEF_MAX_RECORD_BYTES;
  localparam int unsigned LEN_W  = DEF_LEN_W;
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam int unsigned BUF_W  = MAXB * 8;
  localparam int unsigned BEAT_W = W * 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [BEAT_W-1:0] dataIn = '0;
  logic              dataInValid = 1'b0;
  logic              dataInReady;
  logic [BUF_W-1:0]  recordOut;
  logic [LEN_W-1:0]  recordByteLength;
  logic              recordValid;
  logic              recordReady = 1'b0;
  logic [LVL_W-1:0]  fifoLevel;
  logic              frameErrorPulse;
`ifdef USE_FRAMER_ERRCNT_EN
  logic [15:0]       errCount;
`endif

  int          nCompared = 0;
  int          nMismatched = 0;
  int          errSeen = 0;
  int          errExp = 0;
  int          recSeen = 0;
  logic        randReady = 1'b0;
  record_t     expQ[$];
  logic [7:0]  txQ[$];
  record_t     monRec;

  always #5 clk = ~clk;

  use_record_framer dut (
    .clk              (clk),
    .reset            (reset),
    .dataIn           (dataIn),
    .dataInValid      (dataInValid),
    .dataInReady      (dataInReady),
    .recordOut        (recordOut),
    .recordByteLength (recordByteLength),
    .recordValid      (recordValid),
    .recordReady      (recordReady),
    .fifoLevel        (fifoLevel),
    .frameErrorPulse  (frameErrorPulse)
`ifdef USE_FRAMER_ERRCNT_EN
    ,
    .errCount         (errCount)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every record popped is matched against the next expected record
  always @(negedge clk) begin
    if (reset && frameErrorPulse) errSeen++;
    if (reset && recordValid && recordReady) begin
      recSeen++;
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("FAIL unexpected record: len %0d byte0 %h", recordByteLength, recordOut[7:0]);
      end else begin
        monRec = expQ.pop_front();
        if (recordOut !== monRec.bytes || recordByteLength !== monRec.length) begin
          nMismatched++;
          $display("FAIL record %0d: got len %0d data %h, expected len %0d data %h",
                   recSeen, recordByteLength, recordOut, monRec.length, monRec.bytes);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (randReady) begin
      #1 recordReady = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [7:0] nonDelim();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == DELIM);
    return b;
  endfunction

  function automatic record_t withByte(input record_t r, input int n, input logic [7:0] b);
    record_t o;
    o = r;
    o.bytes = o.bytes | (BUF_W'(b) << (8 * n));
    return o;
  endfunction

  // Well-formed record: varLen bytes, delimiter, F fixed bytes ending in lastFix
  task automatic addGood(input int varLen, input logic [7:0] firstByte, input logic [7:0] lastFix);
    record_t    r;
    logic [7:0] b;
    int         n;
    r = '0;
    n = 0;
    for (int i = 0; i < varLen; i++) begin
      b = (i == 0) ? firstByte : nonDelim();
      txQ.push_back(b); r = withByte(r, n, b); n++;
    end
    txQ.push_back(DELIM); r = withByte(r, n, DELIM); n++;
    for (int i = 0; i < int'(F); i++) begin
      b = (i == int'(F) - 1) ? lastFix : 8'($urandom_range(0, 255));
      txQ.push_back(b); r = withByte(r, n, b); n++;
    end
    r.length = LEN_W'(n);
    expQ.push_back(r);
  endtask

  // Overlong record: produces no output, exactly one error pulse
  task automatic addBad(input int varLen);
    for (int i = 0; i < varLen; i++) txQ.push_back(nonDelim());
    txQ.push_back(DELIM);
    for (int i = 0; i < int'(F); i++) txQ.push_back(8'($urandom_range(0, 255)));
    errExp++;
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, " recordValid"}, 64'(recordValid), 64'(0));
    check({tag, " fifoLevel"}, 64'(fifoLevel), 64'(0));
    check({tag, " recordOut nonzero"}, 64'(recordOut != '0), 64'(0));
    check({tag, " recordByteLength"}, 64'(recordByteLength), 64'(0));
    check({tag, " dataInReady"}, 64'(dataInReady), 64'(1));
    check({tag, " frameErrorPulse"}, 64'(frameErrorPulse), 64'(0));
`ifdef USE_FRAMER_ERRCNT_EN
    check({tag, " errCount"}, 64'(errCount), 64'(0));
`endif
  endtask

  task automatic clearModel();
    expQ.delete(); txQ.delete();
    errSeen = 0; errExp = 0; recSeen = 0;
  endtask

  task automatic doReset();
    randReady = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; dataInValid = 1'b0; recordReady = 1'b0; dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    clearModel();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // mode 0: back-to-back, 1: valid toggles 1-0, 2: random idle cycles
  task automatic sendBeats(input int nb, input int mode);
    logic [BEAT_W-1:0] beat;
    logic              accepted;
    int                waited;
    for (int k = 0; k < nb; k++) begin
      beat = '0;
      for (int j = 0; j < int'(W); j++) begin
        if (txQ.size() > 0) beat = beat | (BEAT_W'(txQ.pop_front()) << (8 * j));
      end
      if (mode == 2 && $urandom_range(0, 2) == 0) begin
        dataInValid = 1'b0; @(posedge clk); #1;
      end
      dataIn = beat; dataInValid = 1'b1;
      accepted = 1'b0; waited = 0;
      while (!accepted && waited < 500) begin
        @(negedge clk); accepted = dataInReady;
        @(posedge clk); #1; waited++;
      end
      if (!accepted) begin
        nCompared++; nMismatched++;
        $display("FAIL beat accept timeout: dataInReady stuck at 0, expected 1");
      end
      dataInValid = 1'b0;
      if (mode == 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic sendAll(input int mode);
    sendBeats((txQ.size() + int'(W) - 1) / int'(W), mode);
  endtask

  task automatic drain();
    int waited;
    randReady = 1'b0;
    @(posedge clk); #1;
    recordReady = 1'b1;
    waited = 0;
    while (expQ.size() > 0 && waited < 2000) begin
      @(posedge clk); #1; waited++;
    end
    if (expQ.size() > 0) begin
      nCompared++; nMismatched++;
      $display("FAIL drain timeout: %0d records outstanding, expected 0", expQ.size());
    end
    repeat (4) @(posedge clk);
    #1;
    check("no extra record", 64'(recordValid), 64'(0));
  endtask

  typedef struct {
    int varLen;
    int expLen;
    int expRecs;
    int expErrs;
  } vec_t;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[6];
    int   lens[20];

    vecs[0] = '{varLen: 0,  expLen: 18, expRecs: 1, expErrs: 0};
    vecs[1] = '{varLen: 1,  expLen: 19, expRecs: 1, expErrs: 0};
    vecs[2] = '{varLen: 15, expLen: 33, expRecs: 1, expErrs: 0};
    vecs[3] = '{varLen: 16, expLen: 34, expRecs: 1, expErrs: 0};
    vecs[4] = '{varLen: 17, expLen: 0,  expRecs: 0, expErrs: 1};
    vecs[5] = '{varLen: 24, expLen: 0,  expRecs: 0, expErrs: 1};
    lens = '{27, 21, 21, 24, 31, 19, 26, 23, 33, 33, 31, 19, 19, 20, 29, 19, 30, 19, 20, 21};

    // Single-record boundary table, zero-length variable field has byte0 = delimiter
    for (int v = 0; v < 6; v++) begin
      doReset();
      if (vecs[v].expRecs != 0) begin
        addGood(vecs[v].varLen, 8'h41, DELIM);
        expQ[expQ.size()-1].length = LEN_W'(vecs[v].expLen);
      end else begin
        addBad(vecs[v].varLen);
      end
      recordReady = 1'b1;
      sendAll(0);
      drain();
      check($sformatf("vec%0d records", v), 64'(recSeen), 64'(vecs[v].expRecs));
      check($sformatf("vec%0d errors", v), 64'(errSeen), 64'(vecs[v].expErrs));
`ifdef USE_FRAMER_ERRCNT_EN
      check($sformatf("vec%0d errCount", v), 64'(errCount), 64'(vecs[v].expErrs));
`endif
    end

    // 20 back-to-back records, then the same with dataInValid toggling
    for (int mode = 0; mode < 2; mode++) begin
      doReset();
      for (int i = 0; i < 20; i++) addGood(lens[i] - int'(F) - 1, 8'(i), DELIM);
      recordReady = 1'b1;
      sendAll(mode);
      drain();
      check($sformatf("stream mode%0d records", mode), 64'(recSeen), 64'(20));
      check($sformatf("stream mode%0d errors", mode), 64'(errSeen), 64'(0));
    end

    // Backpressure: FIFO fills at the 4th record, nothing is lost
    doReset();
    for (int i = 0; i < 5; i++) addGood(3, 8'(8'h10 + i), 8'h00);
    recordReady = 1'b0;
    fork
      sendAll(0);
      begin
        int waited;
        waited = 0;
        @(negedge clk);
        while (dataInReady && waited < 300) begin @(negedge clk); waited++; end
        check("full fifoLevel", 64'(fifoLevel), 64'(DEPTH));
        check("full dataInReady", 64'(dataInReady), 64'(0));
        check("full recordValid", 64'(recordValid), 64'(1));
        repeat (10) @(negedge clk);
        check("held fifoLevel", 64'(fifoLevel), 64'(DEPTH));
        check("held recSeen", 64'(recSeen), 64'(0));
        @(posedge clk); #1;
        recordReady = 1'b1;
      end
    join
    drain();
    check("backpressure records", 64'(recSeen), 64'(5));

    // Overlong field recovery followed by a good record
    doReset();
    addBad(20);
    addGood(3, 8'h55, 8'h99);
    recordReady = 1'b1;
    sendAll(0);
    drain();
    check("recover records", 64'(recSeen), 64'(1));
    check("recover pulses", 64'(errSeen), 64'(1));
`ifdef USE_FRAMER_ERRCNT_EN
    check("recover errCount", 64'(errCount), 64'(1));
`endif

    // Asynchronous reset in the middle of the 3rd record
    doReset();
    for (int i = 0; i < 5; i++) addGood(3, 8'(8'h20 + i), 8'h00);
    recordReady = 1'b0;
    sendBeats(7, 0);
    check("pre-reset fifoLevel", 64'(fifoLevel), 64'(2));
    reset = 1'b0;
    #1;
    checkResetValues("async reset");
    @(posedge clk); #1;
    clearModel();
    reset = 1'b1;
    @(posedge clk); #1;
    addGood(3, 8'h31, 8'h00);
    addGood(5, 8'h32, DELIM);
    recordReady = 1'b1;
    sendAll(0);
    drain();
    check("post-reset records", 64'(recSeen), 64'(2));

    // Randomized mix with random valid gaps and random recordReady
    doReset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) addBad(int'($urandom_range(V + 1, V + 10)));
      else addGood(int'($urandom_range(0, V)), nonDelim(), 8'($urandom_range(0, 255)));
    end
    begin
      int goodRecs;
      goodRecs = expQ.size();
      randReady = 1'b1;
      sendAll(2);
      drain();
      check("random records", 64'(recSeen), 64'(goodRecs));
      check("random pulses", 64'(errSeen), 64'(errExp));
`ifdef USE_FRAMER_ERRCNT_EN
      check("random errCount", 64'(errCount), 64'(errExp));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
